// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit (with common_pkg)
// Brief    : RV64I fetch stage. Owns the PC, issues one word-aligned read at
//            a time and buffers returned instructions in a 2-entry queue that
//            feeds decode over valid/ready. Redirects flush the queue and
//            discard any in-flight response; misaligned targets park the
//            unit in a sticky fault state until reset.
// Revision : 1.0 - initial release
// ============================================================================

package common_pkg;
  typedef enum logic [6:0] {
    OPC_LOAD      = 7'b0000011,
    OPC_MISC_MEM  = 7'b0001111,
    OPC_OP_IMM    = 7'b0010011,
    OPC_AUIPC     = 7'b0010111,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_STORE     = 7'b0100011,
    OPC_OP        = 7'b0110011,
    OPC_LUI       = 7'b0110111,
    OPC_OP_32     = 7'b0111011,
    OPC_BRANCH    = 7'b1100011,
    OPC_JALR      = 7'b1100111,
    OPC_JAL       = 7'b1101111,
    OPC_SYSTEM    = 7'b1110011
  } opcode_t;
endpackage

module instr_fetch_unit
  import common_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  // decode side
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc,
  output opcode_t         if_opcode,
  // redirect and fault
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,  // nothing outstanding
    ST_WAIT  = 2'd1,  // one outstanding, response will be queued
    ST_DROP  = 2'd2,  // one outstanding, response will be discarded
    ST_FAULT = 2'd3   // misaligned redirect seen; frozen until reset
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;

  logic [XLEN-1:0] q_pc   [2];
  logic [31:0]     q_inst [2];
  logic            head;
  logic            tail;
  logic [1:0]      count;

  logic            accept;
  logic            redir_ok;
  logic            redir_bad;
  logic            flush;
  logic            push;
  logic            pop;

  // Redirects are ignored once faulted; alignment decides which kind it is.
  assign redir_ok  = redirect_valid && (state != ST_FAULT) && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (state != ST_FAULT) && (redirect_pc[1:0] != 2'b00);
  assign flush     = redir_ok || redir_bad;

  // rst_n gates the request so nothing is offered while reset is held.
  assign imem_req_valid = rst_n && (state == ST_ISSUE) && (count < 2'd2) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Any redirect in the same cycle as a response makes that response stale.
  assign push = (state == ST_WAIT) && imem_resp_valid && !redirect_valid;

  assign if_valid  = (count != 2'd0) && (state != ST_FAULT);
  assign if_inst   = q_inst[head];
  assign if_pc     = q_pc[head];
  assign if_opcode = opcode_t'(q_inst[head][6:0]);
  assign pop       = if_valid && if_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ISSUE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: track the single outstanding request and its fate.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ISSUE: if (accept) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem_resp_valid) state_nxt = ST_ISSUE;
        else if (redir_ok)   state_nxt = ST_DROP;
      end
      ST_DROP:  if (imem_resp_valid) state_nxt = ST_ISSUE;
      default:  state_nxt = ST_FAULT;
    endcase
    if (redir_bad) state_nxt = ST_FAULT;
  end

  // Program counter and the PC of the request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (redir_ok) begin
      pc <= redirect_pc;
    end else if (accept) begin
      req_pc <= pc;
      pc     <= pc + XLEN'(4);
    end
  end

  // Two-entry instruction queue; a flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
      q_inst[0] <= '0;
      q_inst[1] <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        q_pc[tail]   <= req_pc;
        q_inst[tail] <= imem_resp_data;
        tail         <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Sticky fault flag and the offending target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redir_bad) begin
      fault    <= 1'b1;
      fault_pc <= redirect_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed bench for instr_fetch_unit with a queue-based reference
//            model, a latency-programmable memory responder and literal
//            checkpoints for the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
  import common_pkg::*;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  opcode_t     if_opcode;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fault;
  logic [63:0] fault_pc;

  instr_fetch_unit #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .if_opcode(if_opcode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed LOAD at 0x1000, elsewhere a mix of opcodes.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [6:0] op;
    if (a == 64'h1000) return 32'h00F23403;
    case (a[3:2])
      2'd0:    op = 7'b0000011;
      2'd1:    op = 7'b0010011;
      2'd2:    op = 7'b1100011;
      default: op = 7'b1101111;
    endcase
    return {a[26:2], op};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc;
  int          m_out;        // 0 none in flight, 1 keep its data, 2 discard it
  logic [63:0] m_out_pc;
  logic        m_fault;
  logic [63:0] m_fault_pc;
  logic        m_acc = 1'b0;
  logic [63:0] m_acc_addr;

  // Compare DUT against the model just before each rising edge, then advance it.
  always @(negedge clk) begin
    logic exp_req, exp_val;
    #4;
    if (!rst_n) begin
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_req_addr",  imem_req_addr, RST_PC);
      chk("rst_if_valid",  64'(if_valid), 64'd0);
      chk("rst_if_inst",   64'(if_inst), 64'd0);
      chk("rst_if_pc",     if_pc, 64'd0);
      chk("rst_fault",     64'(fault), 64'd0);
      chk("rst_fault_pc",  fault_pc, 64'd0);
      m_q.delete();
      m_pc = RST_PC; m_out = 0; m_fault = 1'b0; m_fault_pc = '0; m_acc = 1'b0;
    end else begin
      exp_req = !m_fault && (m_out == 0) && (m_q.size() < 2) && !redirect_valid;
      exp_val = !m_fault && (m_q.size() > 0);
      chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
      chk("req_addr",  imem_req_addr, m_pc);
      chk("if_valid",  64'(if_valid), 64'(exp_val));
      if (exp_val) begin
        chk("if_pc",     if_pc, m_q[0].pc);
        chk("if_inst",   64'(if_inst), 64'(m_q[0].inst));
        chk("if_opcode", 64'(if_opcode), 64'(m_q[0].inst[6:0]));
      end
      chk("fault",    64'(fault), 64'(m_fault));
      chk("fault_pc", fault_pc, m_fault_pc);

      m_acc      = exp_req && imem_req_ready;
      m_acc_addr = m_pc;
      if (!m_fault) begin
        if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
          m_fault = 1'b1; m_fault_pc = redirect_pc; m_q.delete(); m_out = 0;
        end else if (redirect_valid) begin
          m_q.delete();
          m_pc  = redirect_pc;
          m_out = (m_out != 0 && !imem_resp_valid) ? 2 : 0;
        end else begin
          if (exp_val && if_ready) void'(m_q.pop_front());
          if (m_out != 0 && imem_resp_valid) begin
            if (m_out == 1) m_q.push_back('{pc: m_out_pc, inst: imem_resp_data});
            m_out = 0;
          end
          if (m_acc) begin
            m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 64'd4;
          end
        end
      end
    end
  end

  // ---------------- memory responder and stimulus ----------------
  int          mem_lat = 1;
  bit          mem_busy = 0;
  int          mem_cnt;
  logic [63:0] mem_addr;

  // Advance to the next falling edge and drive this cycle's memory response.
  task automatic cyc();
    @(negedge clk);
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEADBEEF;
    if (m_acc) begin
      mem_busy = 1; mem_cnt = mem_lat; mem_addr = m_acc_addr;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_busy        = 0;
      end
    end
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (m_acc) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_accept: no request accepted within 20 cycles");
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 12 && !if_valid; i++) cyc();
    #2;
    chk("wait_valid", 64'(if_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
    imem_resp_data = '0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) cyc();

    // First fetch after reset, queue fill with decode stalled.
    rst_n = 1'b1;
    #2 chk("c0_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c0_req_addr", imem_req_addr, 64'h1000);
    cyc(); #2 chk("c1_if_valid", 64'(if_valid), 64'd0);
    cyc(); #2 chk("c2_if_valid", 64'(if_valid), 64'd1);
    chk("c2_if_pc", if_pc, 64'h1000);
    chk("c2_if_inst", 64'(if_inst), 64'h00F23403);
    chk("c2_opcode_load", 64'(if_opcode), 64'(7'b0000011));
    chk("c2_req_addr", imem_req_addr, 64'h1004);
    cyc(); cyc();
    #2 chk("full_req_valid", 64'(imem_req_valid), 64'd0);
    chk("full_req_addr", imem_req_addr, 64'h1008);
    chk("full_head_pc", if_pc, 64'h1000);
    repeat (3) cyc();
    #2 chk("stall_head_pc", if_pc, 64'h1000);

    // Drain and resume.
    if_ready = 1'b1;
    cyc(); #2 chk("drain_pc2", if_pc, 64'h1004);
    chk("resume_req_valid", 64'(imem_req_valid), 64'd1);
    chk("resume_req_addr", imem_req_addr, 64'h1008);
    cyc(); #2 chk("drain_empty", 64'(if_valid), 64'd0);
    cyc(); #2 chk("resume_pc", if_pc, 64'h1008);

    // Redirect while waiting; the response lands one cycle later.
    mem_lat = 2;
    wait_accept();
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    cyc(); #2 chk("drop_if_valid", 64'(if_valid), 64'd0);
    chk("drop_req_valid", 64'(imem_req_valid), 64'd0);
    cyc(); #2 chk("post_drop_req_addr", imem_req_addr, 64'h2000);
    chk("post_drop_req_valid", 64'(imem_req_valid), 64'd1);
    wait_valid();
    chk("redir_first_pc", if_pc, 64'h2000);

    // Redirect in the same cycle as the response.
    mem_lat = 1;
    wait_accept();
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    cyc(); #2 chk("same_req_valid", 64'(imem_req_valid), 64'd1);
    chk("same_req_addr", imem_req_addr, 64'h2000);
    chk("same_if_valid", 64'(if_valid), 64'd0);

    // Redirect with pop against a full queue; next PC wraps past 2^64.
    if_ready = 1'b0;
    repeat (6) cyc();
    #2 chk("full2_if_valid", 64'(if_valid), 64'd1);
    chk("full2_req_valid", 64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; if_ready = 1'b1;
    cyc(); #2 chk("wrap_flush", 64'(if_valid), 64'd0);
    chk("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(); #2 chk("wrap_next_addr", imem_req_addr, 64'h0);
    wait_valid();
    chk("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Misaligned redirect: sticky fault, everything else frozen.
    redirect_valid = 1'b1; redirect_pc = 64'h2002;
    cyc(); #2 chk("fault_set", 64'(fault), 64'd1);
    chk("fault_pc_val", fault_pc, 64'h2002);
    for (int i = 0; i < 20; i++) begin
      cyc();
      imem_resp_valid = 1'b1; if_ready = 1'b1;
      if (i == 5) begin redirect_valid = 1'b1; redirect_pc = 64'h3000; end
      #2 chk("fault_req_valid", 64'(imem_req_valid), 64'd0);
      chk("fault_if_valid", 64'(if_valid), 64'd0);
    end
    chk("fault_pc_kept", fault_pc, 64'h2002);

    // Reset asserted mid-request, then a stale response after release.
    rst_n = 1'b0; mem_busy = 0;
    repeat (2) cyc();
    rst_n = 1'b1; if_ready = 1'b0; mem_lat = 1;
    wait_accept();
    cyc(); cyc();
    #1 chk("pre_rst_if_valid", 64'(if_valid), 64'd1);
    rst_n = 1'b0;
    #1 chk("async_req_valid", 64'(imem_req_valid), 64'd0);
    chk("async_req_addr", imem_req_addr, RST_PC);
    chk("async_if_valid", 64'(if_valid), 64'd0);
    chk("async_if_pc", if_pc, 64'd0);
    mem_busy = 0;
    repeat (2) cyc();
    rst_n = 1'b1; if_ready = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h12345678;
    #2 chk("rel_req_addr", imem_req_addr, RST_PC);
    cyc(); #2 chk("rel_c1_if_valid", 64'(if_valid), 64'd0);
    cyc(); #2 chk("rel_if_valid", 64'(if_valid), 64'd1);
    chk("rel_if_pc", if_pc, RST_PC);
    chk("rel_if_inst", 64'(if_inst), 64'h00F23403);
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
